checkpoint_monitor: RTL and testbench

//   Synthesisable, parametrised successor to the bench-side checkpoint watcher for Microwatt bring-up.

---
 rtl/checkpoint_pkg.sv | 14 +
 rtl/checkpoint_monitor_if.sv | 31 +++
 rtl/checkpoint_debounce.sv | 56 +++++
 rtl/checkpoint_monitor.sv | 135 +++++++++++++
 tb/tb_checkpoint_monitor.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/checkpoint_pkg.sv
// Shared types for the checkpoint monitor: FSM stage encoding and the width of the stage output.
package checkpoint_pkg;

    localparam int unsigned STAGE_W = 3;

    typedef enum logic [STAGE_W-1:0] {
        IDLE       = 3'd0,
        WAIT_BOOT  = 3'd1,
        WAIT_ALIVE = 3'd2,
        RUN        = 3'd3,
        DONE       = 3'd4
    } stage_t;

endpackage

// File: rtl/checkpoint_monitor_if.sv
// Progress-code input, run control and verdict/status bundle of the checkpoint monitor.
interface checkpoint_monitor_if #(
    parameter int unsigned WIDTH = 4
);
    import checkpoint_pkg::*;

    logic               enable;
    logic [WIDTH-1:0]   check_i;
    logic [STAGE_W-1:0] stage_o;
    logic               event_o;
    logic [WIDTH-1:0]   event_code_o;
    logic               done_o;
    logic               pass_o;
    logic               fail_o;
    logic               unknown_o;
    logic               timeout_o;
    logic [WIDTH-1:0]   final_code_o;
    logic [31:0]        cycles_o;

    modport master (
        output enable, check_i,
        input  stage_o, event_o, event_code_o, done_o, pass_o, fail_o,
               unknown_o, timeout_o, final_code_o, cycles_o
    );

    modport slave (
        input  enable, check_i,
        output stage_o, event_o, event_code_o, done_o, pass_o, fail_o,
               unknown_o, timeout_o, final_code_o, cycles_o
    );
endinterface

// File: rtl/checkpoint_debounce.sv
// Two-flop synchroniser plus stability filter; flags a newly stable code for exactly one cycle.
module checkpoint_debounce #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] raw,
    output logic             accept_c,
    output logic [WIDTH-1:0] code_c
);

    localparam int unsigned       CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;

    // Run length of identical synchronised samples, saturating at the threshold.
    always_comb begin
        cnt_next = CNT_W'(1);
        if (sync2_q == cand_q) begin
            cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    // Last accepted value guards against re-reporting a code that merely re-stabilised.
    assign accept_c = enable && (cnt_next == CNT_MAX) && (sync2_q != last_q);
    assign code_c   = sync2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (enable) begin
                cand_q <= sync2_q;
                cnt_q  <= cnt_next;
                if (accept_c) begin
                    last_q <= sync2_q;
                end
            end
        end
    end

endmodule

// File: rtl/checkpoint_monitor.sv
// Tracks the boot -> alive -> pass/fail checkpoint sequence with a cycle timeout and sticky verdict.
module checkpoint_monitor
    import checkpoint_pkg::*;
#(
    parameter int unsigned      WIDTH          = 4,
    parameter logic [WIDTH-1:0] CODE_BOOT      = WIDTH'(4'h1),
    parameter logic [WIDTH-1:0] CODE_ALIVE     = WIDTH'(4'h2),
    parameter logic [WIDTH-1:0] CODE_PASS      = WIDTH'(4'h3),
    parameter logic [WIDTH-1:0] CODE_FAIL      = WIDTH'(4'hf),
    parameter int unsigned      STABLE_CYCLES  = 4,
    parameter int unsigned      TIMEOUT_CYCLES = 500000
) (
    input logic                  clock,
    input logic                  reset,
    checkpoint_monitor_if.slave  mon
);

    localparam logic [31:0] CYC_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] CYC_SAT  = 32'hFFFF_FFFF;

    logic             accept_c;
    logic [WIDTH-1:0] code_c;

    stage_t           state_q,      state_d;
    logic             done_q,       done_d;
    logic             pass_q,       pass_d;
    logic             fail_q,       fail_d;
    logic             unknown_q,    unknown_d;
    logic             timeout_q,    timeout_d;
    logic [WIDTH-1:0] final_q,      final_d;
    logic [31:0]      cycles_q,     cycles_d;
    logic             event_q,      event_d;
    logic [WIDTH-1:0] event_code_q, event_code_d;
    logic             verdict;
    logic             active;

    checkpoint_debounce #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .clock    (clock),
        .reset    (reset),
        .enable   (mon.enable),
        .raw      (mon.check_i),
        .accept_c (accept_c),
        .code_c   (code_c)
    );

    assign active = (state_q == WAIT_BOOT) || (state_q == WAIT_ALIVE) || (state_q == RUN);

    // Next state, sticky verdict and elapsed-cycle bookkeeping.
    always_comb begin
        state_d      = state_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        unknown_d    = unknown_q;
        timeout_d    = timeout_q;
        final_d      = final_q;
        cycles_d     = cycles_q;
        verdict      = 1'b0;
        event_d      = accept_c;
        event_code_d = accept_c ? code_c : event_code_q;

        if (mon.enable) begin
            unique case (state_q)
                IDLE:       state_d = WAIT_BOOT;
                WAIT_BOOT:  if (accept_c && code_c == CODE_BOOT)  state_d = WAIT_ALIVE;
                WAIT_ALIVE: if (accept_c && code_c == CODE_ALIVE) state_d = RUN;
                RUN: begin
                    if (accept_c && code_c != CODE_ALIVE) begin
                        state_d   = DONE;
                        verdict   = 1'b1;
                        final_d   = code_c;
                        pass_d    = (code_c == CODE_PASS);
                        fail_d    = (code_c == CODE_FAIL);
                        unknown_d = (code_c != CODE_PASS) && (code_c != CODE_FAIL);
                    end
                end
                DONE:       state_d = DONE;
                default:    state_d = IDLE;
            endcase

            // A code verdict in the same cycle outranks the timeout.
            if (active) begin
                if (!verdict && cycles_q == CYC_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    final_d   = '0;
                end else if (state_d != DONE && cycles_q != CYC_SAT) begin
                    cycles_d = cycles_q + 32'd1;
                end
            end
        end

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            unknown_q    <= 1'b0;
            timeout_q    <= 1'b0;
            final_q      <= '0;
            cycles_q     <= '0;
            event_q      <= 1'b0;
            event_code_q <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            unknown_q    <= unknown_d;
            timeout_q    <= timeout_d;
            final_q      <= final_d;
            cycles_q     <= cycles_d;
            event_q      <= event_d;
            event_code_q <= event_code_d;
        end
    end

    assign mon.stage_o      = STAGE_W'(state_q);
    assign mon.event_o      = event_q;
    assign mon.event_code_o = event_code_q;
    assign mon.done_o       = done_q;
    assign mon.pass_o       = pass_q;
    assign mon.fail_o       = fail_q;
    assign mon.unknown_o    = unknown_q;
    assign mon.timeout_o    = timeout_q;
    assign mon.final_code_o = final_q;
    assign mon.cycles_o     = cycles_q;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// Bench for checkpoint_monitor: scripted vector table, corner sequences and random codes vs a reference model.
module tb_checkpoint_monitor;
    import checkpoint_pkg::*;

    localparam int unsigned W = 4;
    localparam int unsigned S = 4;
    localparam int unsigned T = 100;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    checkpoint_monitor_if #(.WIDTH(W)) bus ();

    checkpoint_monitor #(
        .WIDTH          (W),
        .CODE_BOOT      (4'h1),
        .CODE_ALIVE     (4'h2),
        .CODE_PASS      (4'h3),
        .CODE_FAIL      (4'hf),
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock (clock),
        .reset (reset),
        .mon   (bus)
    );

    int checks = 0;
    int errors = 0;
    int ev_count = 0;

    // Reference model state: pipeline of raw samples, run length of enabled samples, verdict.
    logic [W-1:0] m_pipe [$];
    logic [W-1:0] m_run_val, m_last, m_evt_code, m_final;
    int           m_run_len;
    stage_t       m_stage;
    logic         m_evt, m_done, m_pass, m_fail, m_unk, m_to;
    logic [31:0]  m_cycles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe = '{};
        m_pipe.push_back('0);
        m_pipe.push_back('0);
        m_run_val = '0; m_run_len = 0; m_last = '0;
        m_stage = IDLE; m_evt = 1'b0; m_evt_code = '0;
        m_done = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_unk = 1'b0; m_to = 1'b0;
        m_final = '0; m_cycles = '0;
    endtask

    task automatic model_step(input logic r, input logic en, input logic [W-1:0] code);
        logic [W-1:0] s;
        logic acc, vd, act;
        stage_t nxt;
        if (r) begin
            model_reset();
            return;
        end
        s   = m_pipe[0];
        acc = 1'b0;
        vd  = 1'b0;
        if (en) begin
            if (m_run_len > 0 && s == m_run_val) m_run_len++;
            else begin m_run_val = s; m_run_len = 1; end
            if (m_run_len >= int'(S) && s != m_last) begin acc = 1'b1; m_last = s; end
        end
        m_evt = acc;
        if (acc) m_evt_code = s;
        nxt = m_stage;
        act = (m_stage == WAIT_BOOT || m_stage == WAIT_ALIVE || m_stage == RUN);
        if (en) begin
            if (m_stage == IDLE) nxt = WAIT_BOOT;
            else if (m_stage == WAIT_BOOT && acc && s == 4'h1) nxt = WAIT_ALIVE;
            else if (m_stage == WAIT_ALIVE && acc && s == 4'h2) nxt = RUN;
            else if (m_stage == RUN && acc && s != 4'h2) begin
                nxt = DONE; vd = 1'b1; m_final = s;
                if (s == 4'h3) m_pass = 1'b1;
                else if (s == 4'hf) m_fail = 1'b1;
                else m_unk = 1'b1;
            end
            if (act) begin
                if (!vd && m_cycles == 32'(T - 1)) begin
                    nxt = DONE; m_to = 1'b1; m_final = '0;
                end else if (nxt != DONE && m_cycles != 32'hFFFF_FFFF) begin
                    m_cycles = m_cycles + 32'd1;
                end
            end
        end
        m_stage = nxt;
        m_done  = (nxt == DONE);
        void'(m_pipe.pop_front());
        m_pipe.push_back(code);
    endtask

    task automatic tick(input logic r, input logic en, input logic [W-1:0] code);
        logic [63:0] act, exp;
        reset = r;
        bus.enable = en;
        bus.check_i = code;
        @(posedge clock);
        model_step(r, en, code);
        #1;
        act = 64'({bus.stage_o, bus.event_o, bus.event_code_o, bus.done_o, bus.pass_o, bus.fail_o,
                   bus.unknown_o, bus.timeout_o, bus.final_code_o, bus.cycles_o});
        exp = 64'({STAGE_W'(m_stage), m_evt, m_evt_code, m_done, m_pass, m_fail,
                   m_unk, m_to, m_final, m_cycles});
        chk("model", act, exp);
        if (bus.event_o) ev_count++;
    endtask

    typedef struct {
        logic         rst;
        logic         en;
        logic [W-1:0] code;
        int           hold;
        stage_t       stage;
        logic [3:0]   flags;   // {pass, fail, unknown, timeout}
        logic [W-1:0] fin;
        int           events;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bus.enable  = 1'b0;
        bus.check_i = '0;
        model_reset();

        // Scripted pass / fail / unknown-then-terminal / timeout sequences.
        vecs.push_back('{1'b1, 1'b0, 4'h0,   2, IDLE,       4'b0000, 4'h0, 0});
        vecs.push_back('{1'b0, 1'b1, 4'h1,  20, WAIT_ALIVE, 4'b0000, 4'h0, 1});
        vecs.push_back('{1'b0, 1'b1, 4'h2,  20, RUN,        4'b0000, 4'h0, 1});
        vecs.push_back('{1'b0, 1'b1, 4'h3,  20, DONE,       4'b1000, 4'h3, 1});
        vecs.push_back('{1'b1, 1'b0, 4'h0,   2, IDLE,       4'b0000, 4'h0, 0});
        vecs.push_back('{1'b0, 1'b1, 4'h1,  20, WAIT_ALIVE, 4'b0000, 4'h0, 1});
        vecs.push_back('{1'b0, 1'b1, 4'h2,  20, RUN,        4'b0000, 4'h0, 1});
        vecs.push_back('{1'b0, 1'b1, 4'hf,  20, DONE,       4'b0100, 4'hf, 1});
        vecs.push_back('{1'b1, 1'b0, 4'h0,   2, IDLE,       4'b0000, 4'h0, 0});
        vecs.push_back('{1'b0, 1'b1, 4'h1,  20, WAIT_ALIVE, 4'b0000, 4'h0, 1});
        vecs.push_back('{1'b0, 1'b1, 4'h2,  20, RUN,        4'b0000, 4'h0, 1});
        vecs.push_back('{1'b0, 1'b1, 4'h7,  20, DONE,       4'b0010, 4'h7, 1});
        vecs.push_back('{1'b0, 1'b1, 4'h3,  20, DONE,       4'b0010, 4'h7, 1});
        vecs.push_back('{1'b1, 1'b0, 4'h0,   2, IDLE,       4'b0000, 4'h0, 0});
        vecs.push_back('{1'b0, 1'b1, 4'h1, 120, DONE,       4'b0001, 4'h0, 1});

        foreach (vecs[i]) begin
            ev_count = 0;
            for (int k = 0; k < vecs[i].hold; k++) tick(vecs[i].rst, vecs[i].en, vecs[i].code);
            chk($sformatf("row%0d stage", i), 64'(bus.stage_o), 64'(vecs[i].stage));
            chk($sformatf("row%0d flags", i),
                64'({bus.pass_o, bus.fail_o, bus.unknown_o, bus.timeout_o}), 64'(vecs[i].flags));
            chk($sformatf("row%0d final", i), 64'(bus.final_code_o), 64'(vecs[i].fin));
            chk($sformatf("row%0d done", i), 64'(bus.done_o), 64'(vecs[i].stage == DONE));
            chk($sformatf("row%0d events", i), 64'(ev_count), 64'(vecs[i].events));
        end
        chk("timeout cycles", 64'(bus.cycles_o), 64'(T - 1));

        // Short glitch in RUN must not produce an event or verdict; a held PASS then does.
        tick(1'b1, 1'b0, 4'h0);
        repeat (20) tick(1'b0, 1'b1, 4'h1);
        repeat (20) tick(1'b0, 1'b1, 4'h2);
        chk("glitch pre stage", 64'(bus.stage_o), 64'(RUN));
        ev_count = 0;
        repeat (2)  tick(1'b0, 1'b1, 4'h3);
        repeat (10) tick(1'b0, 1'b1, 4'h2);
        chk("glitch events", 64'(ev_count), 64'd0);
        chk("glitch stage", 64'(bus.stage_o), 64'(RUN));
        chk("glitch done", 64'(bus.done_o), 64'd0);
        repeat (20) tick(1'b0, 1'b1, 4'h3);
        chk("glitch pass", 64'({bus.done_o, bus.pass_o, bus.final_code_o}), 64'({1'b1, 1'b1, 4'h3}));

        // Reset in RUN aborts; PASS alone then only leaves us in WAIT_BOOT; enable low freezes.
        tick(1'b1, 1'b0, 4'h0);
        repeat (20) tick(1'b0, 1'b1, 4'h1);
        repeat (20) tick(1'b0, 1'b1, 4'h2);
        chk("abort pre stage", 64'(bus.stage_o), 64'(RUN));
        tick(1'b1, 1'b1, 4'h3);
        chk("abort reset stage", 64'(bus.stage_o), 64'(IDLE));
        repeat (20) tick(1'b0, 1'b1, 4'h3);
        chk("abort stage", 64'(bus.stage_o), 64'(WAIT_BOOT));
        chk("abort verdict", 64'({bus.done_o, bus.pass_o, bus.fail_o, bus.unknown_o, bus.timeout_o}), 64'd0);
        chk("abort cycles", 64'(bus.cycles_o), 64'd19);
        repeat (50) tick(1'b0, 1'b0, 4'h1);
        chk("freeze cycles", 64'(bus.cycles_o), 64'd19);
        chk("freeze stage", 64'(bus.stage_o), 64'(WAIT_BOOT));

        // Random code segments with occasional enable drops and resets.
        for (int seg = 0; seg < 400; seg++) begin
            logic [W-1:0] c;
            logic en, r;
            int hold;
            case ($urandom_range(0, 6))
                0: c = 4'h0;
                1: c = 4'h1;
                2: c = 4'h2;
                3: c = 4'h3;
                4: c = 4'hf;
                5: c = 4'h7;
                default: c = W'($urandom);
            endcase
            hold = int'($urandom_range(1, 12));
            en   = ($urandom_range(0, 9) != 0);
            r    = ($urandom_range(0, 39) == 0);
            if (r) tick(1'b1, en, c);
            for (int k = 0; k < hold; k++) tick(1'b0, en, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
